// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter and its data mux.
//   N_PORTS  : number of requesters
//   WORD_W   : data word width
//   SEL_W    : width of a requester index / mux select
//   rr_pick  : round-robin scan of a valid vector starting at ptr
package arb_pkg;

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  // Scan ptr, ptr+1, ... (mod N_PORTS); first valid index wins.
  // Iterating from the farthest offset down lets the nearest one overwrite.
  function automatic pick_t rr_pick(input logic [N_PORTS-1:0] valid, input sel_t ptr);
    pick_t r;
    sel_t  idx;
    r = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (valid[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_32.sv
// Four-input 32-bit word multiplexer.
//   a : four packed words, word i at [32*i+31:32*i]
//   s : word select
//   y : selected word
module mux4_32
  import arb_pkg::*;
(
  input  logic [N_PORTS*WORD_W-1:0] a,
  input  sel_t                      s,
  output logic [WORD_W-1:0]         y
);

  always_comb begin
    y = '0;
    case (s)
      2'd0:    y = a[0*WORD_W +: WORD_W];
      2'd1:    y = a[1*WORD_W +: WORD_W];
      2'd2:    y = a[2*WORD_W +: WORD_W];
      default: y = a[3*WORD_W +: WORD_W];
    endcase
  end

endmodule

// File: rtl/rr_arb4_32.sv
// Four-requester round-robin arbiter with a single registered output buffer.
// A requester may hold priority for up to BURST consecutive grants before
// priority rotates past it.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : four packed requester words
//   in_valid   : per-requester valid
//   in_ready   : per-requester ready (one-hot or zero, combinational)
//   out_data   : registered selected word
//   out_src    : requester index that produced out_data
//   out_valid  : out_data holds a word
//   out_ready  : downstream accepts the word
//   sel        : current mux select (winner, or ptr when idle)
module rr_arb4_32
  import arb_pkg::*;
#(
  parameter  int unsigned BURST = 1,
  localparam int unsigned CNT_W = $clog2(BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS*WORD_W-1:0] in_data,
  input  logic [N_PORTS-1:0]        in_valid,
  output logic [N_PORTS-1:0]        in_ready,
  output logic [WORD_W-1:0]         out_data,
  output sel_t                      out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output sel_t                      sel
);

  if (BURST < 1 || BURST > 15) begin : g_burst_range
    $error("rr_arb4_32: BURST must be in 1..15");
  end

  sel_t             ptr;
  logic [CNT_W-1:0] cnt;
  pick_t            pick;
  logic             can_load;
  logic             xfer;
  logic [WORD_W-1:0] mux_y;

  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W:0]   cnt_inc;
  logic             rotate;
  sel_t             ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign pick     = rr_pick(in_valid, ptr);
  assign sel      = pick.found ? pick.idx : ptr;
  assign can_load = ~out_valid | out_ready;
  assign xfer     = ~rst & can_load & pick.found;

  mux4_32 u_mux (
    .a (in_data),
    .s (sel),
    .y (mux_y)
  );

  // Grant goes to the scan winner only when the buffer can take a word.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[pick.idx] = 1'b1;
  end

  // Burst count only continues while the current priority holder keeps winning.
  always_comb begin
    cnt_base = (pick.idx == ptr) ? cnt : '0;
    cnt_inc  = {1'b0, cnt_base} + (CNT_W + 1)'(1);
    rotate   = cnt_inc >= (CNT_W + 1)'(BURST);
    ptr_nxt  = rotate ? sel_t'(pick.idx + sel_t'(1)) : pick.idx;
    cnt_nxt  = rotate ? '0 : cnt_inc[CNT_W-1:0];
  end

  // Output buffer and priority state; both frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= pick.idx;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
